// File: rtl/pulse_stretcher_pkg.sv
// Shared types for pulse_stretcher: FSM state encoding and its width.
package pulse_stretcher_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } pulse_stretcher_state_t;

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle trigger strobes into level pulses of programmable length.
// Optional post-pulse low holdoff is compiled in with PULSE_STRETCHER_HOLDOFF_EN.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int LEN_WIDTH      = 8,
  parameter int RETRIGGER      = 0,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic [LEN_WIDTH-1:0] length,
  output logic                 out,
  output logic                 busy,
  output logic                 done,
  output logic                 dropped,
  output logic [STATE_W-1:0]   dbg_state
);

  if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
    $error("pulse_stretcher: HOLDOFF_CYCLES must be at least 1");
  end

  pulse_stretcher_state_t state_q, state_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]   len_eff;
  logic                   out_q, out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   dropped_q, dropped_d;
  logic                   finish;
  logic                   drop;

`ifdef PULSE_STRETCHER_HOLDOFF_EN
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  // A zero length still produces a one-cycle pulse.
  assign len_eff = (length == '0) ? LEN_WIDTH'(1) : length;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dropped_q  <= dropped_d;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    finish  = 1'b0;
    drop    = 1'b0;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = ACTIVE;
          cnt_d   = len_eff;
        end
      end
      ACTIVE: begin
        if (trigger && (RETRIGGER != 0)) begin
          cnt_d = len_eff;
        end else begin
          drop = trigger;
          // Last active cycle: the counter reads 1 here.
          if (cnt_q <= LEN_WIDTH'(1)) begin
            finish = 1'b1;
            cnt_d  = '0;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
            state_d    = HOLDOFF;
            hold_cnt_d = HOLD_W'(HOLDOFF_CYCLES);
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end
        end
      end
`ifdef PULSE_STRETCHER_HOLDOFF_EN
      HOLDOFF: begin
        drop = trigger;
        if (hold_cnt_q <= HOLD_W'(1)) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    out_d     = (state_d == ACTIVE);
    busy_d    = (state_d != IDLE);
    done_d    = finish;
    dropped_d = drop;
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dropped   = dropped_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: two instances (RETRIGGER 0 and 1) share stimulus and are
// checked every cycle against an interval-based model; directed cases pin exact values.
module tb_pulse_stretcher;
  import pulse_stretcher_pkg::*;

  localparam int LW   = 8;
  localparam int HOLD = 4;
`ifdef PULSE_STRETCHER_HOLDOFF_EN
  localparam int MH = HOLD;
`else
  localparam int MH = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          trigger = 1'b0;
  logic [LW-1:0] length = '0;
  logic [1:0]    d_out, d_busy, d_done, d_drop;
  logic [STATE_W-1:0] d_state [2];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pulse_stretcher #(.LEN_WIDTH(LW), .RETRIGGER(0), .HOLDOFF_CYCLES(HOLD)) dut0 (
    .clk(clk), .reset(reset), .trigger(trigger), .length(length),
    .out(d_out[0]), .busy(d_busy[0]), .done(d_done[0]), .dropped(d_drop[0]),
    .dbg_state(d_state[0])
  );

  pulse_stretcher #(.LEN_WIDTH(LW), .RETRIGGER(1), .HOLDOFF_CYCLES(HOLD)) dut1 (
    .clk(clk), .reset(reset), .trigger(trigger), .length(length),
    .out(d_out[1]), .busy(d_busy[1]), .done(d_done[1]), .dropped(d_drop[1]),
    .dbg_state(d_state[1])
  );

  // Model: a pulse is an interval of cycles [start, act_until), followed by MH busy-low
  // cycles ending at idle_at. The "cycle" index is the number of posedges seen.
  longint cyc = 0;
  longint act_until [2] = '{0, 0};
  longint idle_at   [2] = '{0, 0};
  bit m_out [2]  = '{0, 0};
  bit m_busy [2] = '{0, 0};
  bit m_done [2] = '{0, 0};
  bit m_drop [2] = '{0, 0};

  always @(posedge clk) begin
    bit p_out, p_busy;
    longint leff;
    cyc++;
    leff = (length == 0) ? 1 : longint'(length);
    for (int m = 0; m < 2; m++) begin
      p_out  = m_out[m];
      p_busy = m_busy[m];
      m_drop[m] = 1'b0;
      if (reset) begin
        act_until[m] = cyc;
        idle_at[m]   = cyc;
      end else if (trigger) begin
        if (!p_busy || (p_out && m == 1)) begin
          act_until[m] = cyc + leff;
          idle_at[m]   = act_until[m] + MH;
        end else begin
          m_drop[m] = 1'b1;
        end
      end
      m_out[m]  = (cyc < act_until[m]);
      m_busy[m] = (cyc < idle_at[m]);
      m_done[m] = !reset && p_out && !m_out[m];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        tests++;
        if ({d_out[m], d_busy[m], d_done[m], d_drop[m]} !==
            {m_out[m], m_busy[m], m_done[m], m_drop[m]}) begin
          fails++;
          $display("FAIL model_cmp dut%0d cycle %0d: got out/busy/done/drop=%b%b%b%b expected %b%b%b%b",
                   m, cyc, d_out[m], d_busy[m], d_done[m], d_drop[m],
                   m_out[m], m_busy[m], m_done[m], m_drop[m]);
        end
      end
    end
  end

  // Per-instance event counters for directed checks.
  int oc [2], dc [2], pc [2];
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (d_out[m] === 1'b1)  oc[m]++;
      if (d_done[m] === 1'b1) dc[m]++;
      if (d_drop[m] === 1'b1) pc[m]++;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      oc[m] = 0; dc[m] = 0; pc[m] = 0;
    end
  endtask

  task automatic pulse(input int len);
    trigger = 1'b1;
    length  = LW'(len);
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trigger = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (d_done[0] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_done_timeout", int'(n < 400), 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;

    check("reset_out", int'(d_out), 0);
    check("reset_busy", int'(d_busy), 0);
    check("reset_done_drop", int'({d_done, d_drop}), 0);
    check("reset_state", int'(d_state[0]), int'(IDLE));

    // length 3: one-cycle latency, exactly 3 high cycles, one done, no drop
    clear_counts();
    pulse(3);
    check("len3_latency", int'(d_out[0]), 1);
    check("len3_busy", int'(d_busy[0]), 1);
    tick(20);
    check("len3_width", oc[0], 3);
    check("len3_done", dc[0], 1);
    check("len3_dropped", pc[0], 0);

    clear_counts();
    pulse(0);
    tick(20);
    check("len0_width", oc[0], 1);

    clear_counts();
    pulse(255);
    tick(270);
    check("len255_width", oc[0], 255);
    check("len255_done", dc[0], 1);

    // second trigger two cycles after the first
    clear_counts();
    pulse(5);
    tick(1);
    pulse(5);
    tick(20);
    check("noretrig_width", oc[0], 5);
    check("noretrig_dropped", pc[0], 1);
    check("noretrig_done", dc[0], 1);
    check("retrig_width", oc[1], 7);
    check("retrig_done", dc[1], 1);
    check("retrig_dropped", pc[1], 0);

    // trigger in the done cycle
    pulse(2);
    wait_done();
    check("donecyc_out_low", int'(d_out[0]), 0);
    pulse(2);
`ifdef PULSE_STRETCHER_HOLDOFF_EN
    check("donecyc_holdoff_out", int'(d_out[0]), 0);
    check("donecyc_holdoff_drop", int'(d_drop[0]), 1);
    tick(20);
    // triggers throughout holdoff are dropped; the 5th low cycle accepts
    clear_counts();
    pulse(2);
    wait_done();
    trigger = 1'b1;
    length  = LW'(3);
    tick(5);
    trigger = 1'b0;
    check("holdoff_accept_out", int'(d_out[0]), 1);
    check("holdoff_drops0", pc[0], 4);
    check("holdoff_drops1", pc[1], 4);
`else
    check("donecyc_new_pulse", int'(d_out[0]), 1);
    check("donecyc_no_drop", int'(d_drop[0]), 0);
`endif
    tick(20);

    // reset on cycle 2 of a 6-cycle pulse, with a trigger in the same cycle
    clear_counts();
    pulse(6);
    tick(1);
    reset = 1'b1;
    trigger = 1'b1;
    tick(1);
    check("rst_mid_outputs0", int'({d_out[0], d_busy[0], d_done[0], d_drop[0]}), 0);
    check("rst_mid_outputs1", int'({d_out[1], d_busy[1], d_done[1], d_drop[1]}), 0);
    check("rst_mid_state", int'(d_state[0]), int'(IDLE));
    reset = 1'b0;
    trigger = 1'b0;
    tick(15);
    check("rst_mid_width", oc[0], 2);
    check("rst_mid_no_done", dc[0] + dc[1], 0);

    // randomized phase, checked by the model every cycle
    for (int i = 0; i < 10000; i++) begin
      trigger = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) length = LW'($urandom_range(0, 255));
      else length = LW'($urandom_range(0, 12));
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    trigger = 1'b0;
    tick(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
